// File: rtl/cmd_sched_pkg.sv
// Shared definitions for the keypad command scheduler: calculator status
// codes, command codes (CMD_NOP = 4'b1101) and the scheduler state enum.
// Package name: calc_pkg.
package calc_pkg;

  // Calculator status codes
  localparam logic [1:0] STAT_ERROR = 2'b00;
  localparam logic [1:0] STAT_BUSY  = 2'b01;
  localparam logic [1:0] STAT_READY = 2'b10;

  // Keypad / calculator command codes (digits are 4'd0..4'd9)
  localparam logic [3:0] CMD_ADD  = 4'b1010;
  localparam logic [3:0] CMD_SUB  = 4'b1011;
  localparam logic [3:0] CMD_MUL  = 4'b1100;
  localparam logic [3:0] CMD_NOP  = 4'b1101;
  localparam logic [3:0] CMD_EQ   = 4'b1110;
  localparam logic [3:0] CMD_BKSP = 4'b1111;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    ISSUE      = 2'b01,
    WAIT_READY = 2'b10,
    ERROR      = 2'b11
  } sched_state_e;

  // True for the arithmetic operator codes add/sub/mul
  function automatic logic is_operator(input logic [3:0] code);
    return (code >= CMD_ADD) && (code <= CMD_MUL);
  endfunction

endpackage

// File: rtl/cmd_sched_if.sv
// Keypad-side and calculator-side signals of the command scheduler.
// master: the environment (keypad + calculator); slave: cmd_sched.
interface cmd_sched_if #(
  parameter int DEPTH = 8
) ();

  logic                     key_valid;
  logic [3:0]               key_code;
  logic                     key_ready;
  logic [1:0]               calc_status;
  logic [3:0]               calc_cmd;
  logic [$clog2(DEPTH):0]   level;
  logic                     err;

  modport master (
    output key_valid, key_code, calc_status,
    input  key_ready, calc_cmd, level, err
  );

  modport slave (
    input  key_valid, key_code, calc_status,
    output key_ready, calc_cmd, level, err
  );

endinterface

// File: rtl/cmd_sched_fifo.sv
// cmd_fifo: DEPTH-entry first-in first-out buffer of 4-bit keypad codes.
// Head entry is visible combinationally; push when full and pop when empty
// are ignored; flush empties the buffer and overrides push/pop.
module cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [3:0]                 i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [3:0]                 o_head,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_level   = r_level;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop  && !o_empty;

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clock) begin
    if (!reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/cmd_sched.sv
// cmd_sched: buffers keypad codes in a FIFO and issues them one at a time
// to a calculator, handshaking on its ready/busy/error status.
// Optional feature macro: CMD_SCHED_FILTER_EN -- drops NOP codes and
// repeated operator codes before they reach the FIFO.
module cmd_sched
  import calc_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic       clock,
  input  logic       reset,
  cmd_sched_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  sched_state_e  r_state;
  logic [3:0]    r_cmd;
  logic          r_err;
  logic [HW-1:0] r_hold_cnt;

  logic          w_full;
  logic          w_empty;
  logic [3:0]    w_head;
  logic [LW-1:0] w_level;
  logic          w_key_ready;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_stat_err;
  logic          w_stat_busy;
  logic          w_stat_ready;

  assign w_stat_err   = (bus.calc_status == STAT_ERROR);
  assign w_stat_busy  = (bus.calc_status == STAT_BUSY);
  assign w_stat_ready = (bus.calc_status == STAT_READY);

  // The keypad sees back-pressure when full or once the calculator has failed
  assign w_key_ready = !w_full && (r_state != ERROR);
  assign w_accept    = bus.key_valid && w_key_ready;

  // Only IDLE pops, and only into a ready calculator
  assign w_pop   = (r_state == IDLE) && !w_empty && w_stat_ready;
  // Flush on the same edge that enters ERROR so level reads 0 immediately
  assign w_flush = (r_state == ERROR) || w_stat_err;

`ifdef CMD_SCHED_FILTER_EN
  logic [3:0] r_last_code;
  logic       r_last_vld;
  logic       w_drop;

  // A handshake still completes for dropped codes; only the FIFO write is skipped
  always_comb begin
    w_drop = (bus.key_code == CMD_NOP) ||
             (is_operator(bus.key_code) && r_last_vld && (bus.key_code == r_last_code));
  end

  // Remember the most recently accepted code for repeat detection
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_last_vld <= 1'b0;
    end else if (w_accept) begin
      r_last_vld <= 1'b1;
    end
    if (w_accept) r_last_code <= bus.key_code;
  end

  assign w_push = w_accept && !w_drop;
`else
  assign w_push = w_accept;
`endif

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bus.key_code),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Scheduler FSM: error has priority in every state and is left only by reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cmd      <= CMD_NOP;
      r_err      <= 1'b0;
      r_hold_cnt <= '0;
    end else if (w_stat_err || (r_state == ERROR)) begin
      r_state    <= ERROR;
      r_cmd      <= CMD_NOP;
      r_err      <= 1'b1;
      r_hold_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_cmd      <= w_head;
            r_hold_cnt <= '0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          // Command stays on calc_cmd for at most HOLD_MAX cycles
          if (w_stat_busy || (r_hold_cnt == HOLD_LAST)) begin
            r_cmd      <= CMD_NOP;
            r_hold_cnt <= '0;
            r_state    <= WAIT_READY;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        WAIT_READY: begin
          if (w_stat_ready) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cmd   <= CMD_NOP;
        end
      endcase
    end
  end

  assign bus.key_ready = w_key_ready;
  assign bus.calc_cmd  = r_cmd;
  assign bus.level     = w_level;
  assign bus.err       = r_err;

endmodule
